mem_access_ctrl: RTL

Memory-stage responder that consumes the load/store requests issued by the EX/MEM pipeline register and performs them on a single-port req/ack data bus. It handles byte, half and word access sizing, lane alignment and sign/zero extension, and stalls the pipeline while a transfer is outstanding. Its registered outputs feed the writeback stage.

---
 rtl/mem_access_ctrl.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage load/store responder.
//
// Takes load/store requests from the EX/MEM register and runs them as a
// single transfer on a req/ack data bus. It handles byte/half/word sizing,
// lane placement of store data, and lane extraction with sign/zero extension
// of load data. It stalls upstream (hold_o) while a transfer is outstanding.
// Writeback outputs are registered.
//
// Ports:
//   clk_100MHz, arst            clock, asynchronous active-high reset
//   mem_r_ena_i/mem_r_addr_i    load request and byte address
//   mem_w_ena_i/mem_w_addr_i    store request and byte address
//   mem_w_data_i                right-aligned store data
//   inst_i                      instruction; funct3 = inst_i[14:12]
//   reg_w_ena_i/addr_i/data_i   writeback request from EX/MEM
//   bus_req_o/we_o/addr_o/be_o/wdata_o, bus_ack_i, bus_rdata_i   data bus
//   hold_o                      stall request to upstream pipeline registers
//   reg_w_ena_o/addr_o/data_o   to writeback
//   exc_misalign_o              one-cycle misaligned-access pulse
//   bus_err_o                   one-cycle bus timeout pulse
//
// Optional feature macro: MEM_TIMEOUT_EN. When defined, a transfer with no
// ack is aborted after TIMEOUT BUSY cycles. When undefined, BUSY waits
// forever and bus_err_o stays 0.
module mem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_100MHz,
    input  logic              arst,
    input  logic              mem_r_ena_i,
    input  logic [ADDR_W-1:0] mem_r_addr_i,
    input  logic              mem_w_ena_i,
    input  logic [ADDR_W-1:0] mem_w_addr_i,
    input  logic [DATA_W-1:0] mem_w_data_i,
    input  logic [31:0]       inst_i,
    input  logic              reg_w_ena_i,
    input  logic [4:0]        reg_w_addr_i,
    input  logic [DATA_W-1:0] reg_w_data_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              hold_o,
    output logic              reg_w_ena_o,
    output logic [4:0]        reg_w_addr_o,
    output logic [DATA_W-1:0] reg_w_data_o,
    output logic              exc_misalign_o,
    output logic              bus_err_o
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // funct3[1:0] gives the access size; funct3[2] marks unsigned loads.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   lane_be = 4'b0001 << lane;
            2'b01:   lane_be = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    // Replicate the store data so every enabled lane already holds it.
    function automatic logic [DATA_W-1:0] lane_wdata(input logic [2:0] f3, input logic [DATA_W-1:0] d);
        case (f3[1:0])
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                       input logic [DATA_W-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b100:  load_extract = {24'b0, b};
            3'b101:  load_extract = {16'b0, h};
            default: load_extract = w;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [3:0]          bus_be_q, bus_be_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                reg_w_ena_q, reg_w_ena_d;
    logic [4:0]          reg_w_addr_q, reg_w_addr_d;
    logic [DATA_W-1:0]   reg_w_data_q, reg_w_data_d;
    logic                exc_q, exc_d;
    logic                err_q, err_d;
    // Shape of the outstanding access, needed again when the ack returns.
    logic                ld_q, ld_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          lane_q, lane_d;
    logic                hold_c;

    logic                is_mem;
    logic                is_load;
    logic [ADDR_W-1:0]   op_addr;
    logic [2:0]          f3;
    logic                misalign;

    // A simultaneous load and store request is a load.
    assign is_load  = mem_r_ena_i;
    assign is_mem   = mem_r_ena_i | mem_w_ena_i;
    assign op_addr  = is_load ? mem_r_addr_i : mem_w_addr_i;
    assign f3       = inst_i[14:12];
    assign misalign = is_mem & (((f3[1:0] == 2'b01) & op_addr[0]) |
                                ((f3 == 3'b010) & (op_addr[1:0] != 2'b00)));

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    wire unused_timeout = (TIMEOUT != 0);
`endif
    wire unused_inst = ^{inst_i[31:15], inst_i[11:0]};

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        reg_w_ena_d  = 1'b0;
        reg_w_addr_d = reg_w_addr_q;
        reg_w_data_d = reg_w_data_q;
        exc_d        = 1'b0;
        err_d        = 1'b0;
        ld_d         = ld_q;
        f3_d         = f3_q;
        lane_d       = lane_q;
        hold_c       = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!is_mem) begin
                    reg_w_ena_d  = reg_w_ena_i;
                    reg_w_addr_d = reg_w_addr_i;
                    reg_w_data_d = reg_w_data_i;
                end else if (misalign) begin
                    exc_d = 1'b1;
                end else begin
                    hold_c      = 1'b1;
                    state_d     = BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = ~is_load;
                    bus_addr_d  = {op_addr[ADDR_W-1:2], 2'b00};
                    bus_be_d    = lane_be(f3, op_addr[1:0]);
                    bus_wdata_d = lane_wdata(f3, mem_w_data_i);
                    ld_d        = is_load;
                    f3_d        = f3;
                    lane_d      = op_addr[1:0];
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            BUSY: begin
                if (bus_ack_i) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    if (ld_q) begin
                        reg_w_ena_d  = reg_w_ena_i;
                        reg_w_addr_d = reg_w_addr_i;
                        reg_w_data_d = load_extract(f3_q, lane_q, bus_rdata_i);
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Last allowed cycle with no ack: abort and release the pipeline.
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    hold_c = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
`else
                end else begin
                    hold_c = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            reg_w_ena_q  <= 1'b0;
            reg_w_addr_q <= '0;
            reg_w_data_q <= '0;
            exc_q        <= 1'b0;
            err_q        <= 1'b0;
            ld_q         <= 1'b0;
            f3_q         <= '0;
            lane_q       <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            reg_w_ena_q  <= reg_w_ena_d;
            reg_w_addr_q <= reg_w_addr_d;
            reg_w_data_q <= reg_w_data_d;
            exc_q        <= exc_d;
            err_q        <= err_d;
            ld_q         <= ld_d;
            f3_q         <= f3_d;
            lane_q       <= lane_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_be_o       = bus_be_q;
    assign bus_wdata_o    = bus_wdata_q;
    // hold_o is combinational; force it low during reset so every output is 0.
    assign hold_o         = hold_c & ~arst;
    assign reg_w_ena_o    = reg_w_ena_q;
    assign reg_w_addr_o   = reg_w_addr_q;
    assign reg_w_data_o   = reg_w_data_q;
    assign exc_misalign_o = exc_q;
    assign bus_err_o      = err_q;

endmodule
